// File: rtl/parity_err_monitor_if.sv
// Received-character bus for the parity monitor: per-channel strobes plus
// packed characters, each carrying its received parity bit in the MSB.
interface parity_err_monitor_if #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [CHANNELS-1:0]                in_valid;
    logic [CHANNELS*(DATA_WIDTH+1)-1:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/parity_err_monitor.sv
// Multi-channel received-character parity monitor with registered error pulses,
// saturating per-channel and aggregate error counters, and a threshold interrupt.
module parity_err_monitor #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    parity_err_monitor_if.slave             rx,
    input  logic [1:0]                      parity_mode,
    input  logic                            check_en,
    input  logic [CHANNELS-1:0]             clr,
    input  logic                            clr_total,
    input  logic [CNT_WIDTH-1:0]            threshold,
    output logic [CHANNELS-1:0]             err_pulse,
    output logic [CHANNELS*CNT_WIDTH-1:0]   err_count,
    output logic [CHANNELS-1:0]             saturated,
    output logic [CNT_WIDTH-1:0]            total_count,
    output logic                            irq
);
    localparam int unsigned CW        = DATA_WIDTH + 1;
    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 5;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [SUM_WIDTH-1:0] SUM_MAX = {5'b0, CNT_MAX};

    typedef enum logic [1:0] {
        PM_EVEN  = 2'b00,
        PM_ODD   = 2'b01,
        PM_MARK  = 2'b10,
        PM_SPACE = 2'b11
    } parity_mode_e;

    parity_mode_e         mode;
    logic [CHANNELS-1:0]  err;
    logic [CW-1:0]        ch_word;
    logic                 mismatch;
    logic [SUM_WIDTH-1:0] err_popcount;
    logic [SUM_WIDTH-1:0] total_sum;
    logic                 irq_next;
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];

    assign mode = parity_mode_e'(parity_mode);

    always_comb begin
        err          = '0;
        err_popcount = '0;
        ch_word      = '0;
        mismatch     = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ch_word = rx.in_data[i*CW +: CW];
            case (mode)
                PM_EVEN:  mismatch = ^ch_word;
                PM_ODD:   mismatch = ~^ch_word;
                PM_MARK:  mismatch = ~ch_word[CW-1];
                PM_SPACE: mismatch = ch_word[CW-1];
                default:  mismatch = 1'b0;
            endcase
            err[i]       = rx.in_valid[i] & check_en & mismatch;
            err_popcount = err_popcount + SUM_WIDTH'(err[i]);
        end
    end

    // Widened sum so a full-width count plus every channel's error cannot wrap before clamping.
    assign total_sum = {5'b0, total_count} + err_popcount;

    always_comb begin
        irq_next = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if ((threshold != '0) && (cnt_q[i] >= threshold)) begin
                irq_next = 1'b1;
            end
        end
    end

    always_comb begin
        err_count = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            err_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            err_pulse   <= '0;
            saturated   <= '0;
            total_count <= '0;
            irq         <= 1'b0;
        end else begin
            err_pulse <= err;
            irq       <= irq_next;

            if (clr_total) begin
                total_count <= '0;
            end else if (total_sum > SUM_MAX) begin
                total_count <= CNT_MAX;
            end else begin
                total_count <= total_sum[CNT_WIDTH-1:0];
            end

            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (clr[i]) begin
                    cnt_q[i]     <= '0;
                    saturated[i] <= 1'b0;
                end else if (err[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                    if (cnt_q[i] == CNT_MAX - CNT_WIDTH'(1)) begin
                        saturated[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
